// File: rtl/divu_job_arbiter.sv
// divu_job_arbiter
//   Shares the DIVU internal-bus register port between two job requesters.
//   A job is granted round-robin and then sequenced as bus writes of the
//   divisor and dividend (the last write starts the divide), a fixed wait of
//   DIV_LAT CE_R cycles, and bus reads of quotient and remainder. The result
//   is presented with a one-cycle RES_DONE pulse.
//
//   Optional build macro: DIVU_ARB_OVF_CLR_EN
//     defined   : after the result reads, DVCR is read (OVF -> RES_OVF, OVFIE
//                 kept) and written back with OVF cleared.
//     undefined : DVCR is never accessed, RES_OVF is tied 0.
//
//   Parameter:
//     DIV_LAT  CE_R cycles between the start write and the first result read
//              (must be >= 39).
//
//   Ports:
//     CLK, RST        clock, synchronous active-high reset
//     CE_R            rising-phase enable; state advances only when high
//     Rn_REQ          job request (held until Rn_ACK)
//     Rn_DIV64        1 = 64/32 divide, 0 = 32/32 divide
//     Rn_DVSR/DVDH/DVDL  divisor, dividend high word, dividend low word
//     Rn_ACK          one-cycle grant; operands are latched in this cycle
//     RES_DONE        one-cycle result-valid pulse
//     RES_ID          requester index of the completed job
//     RES_Q/RES_R     quotient / remainder
//     RES_OVF         overflow / zero-divide flag
//     DIV_A/DO/BA/WE/REQ  DIVU bus master outputs (A/DO zero when idle)
//     DIV_DI          DIVU read data
module divu_job_arbiter #(
  parameter int DIV_LAT = 40
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE_R,
  input  logic        R0_REQ,
  input  logic        R0_DIV64,
  input  logic [31:0] R0_DVSR,
  input  logic [31:0] R0_DVDH,
  input  logic [31:0] R0_DVDL,
  output logic        R0_ACK,
  input  logic        R1_REQ,
  input  logic        R1_DIV64,
  input  logic [31:0] R1_DVSR,
  input  logic [31:0] R1_DVDH,
  input  logic [31:0] R1_DVDL,
  output logic        R1_ACK,
  output logic        RES_DONE,
  output logic        RES_ID,
  output logic [31:0] RES_Q,
  output logic [31:0] RES_R,
  output logic        RES_OVF,
  output logic [31:0] DIV_A,
  output logic [31:0] DIV_DO,
  output logic [3:0]  DIV_BA,
  output logic        DIV_WE,
  output logic        DIV_REQ,
  input  logic [31:0] DIV_DI
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  localparam logic [31:0] A_DVSR   = 32'hFFFF_FF00;
  localparam logic [31:0] A_DVDNT  = 32'hFFFF_FF04;
  localparam logic [31:0] A_DVCR   = 32'hFFFF_FF08;
  localparam logic [31:0] A_DVDNTH = 32'hFFFF_FF10;
  localparam logic [31:0] A_DVDNTL = 32'hFFFF_FF14;

  typedef enum logic [3:0] {
    S_DRAIN,
    S_IDLE,
    S_GRANT,
    S_WR_DVSR,
    S_WR_DVDH,
    S_WR_START,
    S_WAIT,
    S_RD_L,
    S_RD_H,
    S_RD_CR,
    S_WR_CR,
    S_DONE
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              rd_ph;     // 0: address phase (DIV_REQ=1), 1: capture phase
  logic              last_id;   // requester served most recently
  logic              gnt_id;    // requester of the job in flight
  logic              gnt_sel;
  logic              is_rd;

  logic              job_div64;
  logic [31:0]       job_dvsr;
  logic [31:0]       job_dvdh;
  logic [31:0]       job_dvdl;
  logic [31:0]       q_cap;
`ifdef DIVU_ARB_OVF_CLR_EN
  logic [31:0]       r_cap;
  logic              ovf_cap;
  logic              ovfie;
`endif

  // On a tie the requester not served last wins.
  assign gnt_sel = (R0_REQ && R1_REQ) ? ~last_id : R1_REQ;

  assign is_rd = (state == S_RD_L) || (state == S_RD_H) || (state == S_RD_CR);

  assign R0_ACK   = (state == S_GRANT) && !gnt_id;
  assign R1_ACK   = (state == S_GRANT) &&  gnt_id;
  assign RES_DONE = (state == S_DONE);
  assign DIV_BA   = DIV_REQ ? 4'hF : 4'h0;

  // Control registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_DRAIN;
      cnt     <= CNT_W'(DIV_LAT);
      rd_ph   <= 1'b0;
      last_id <= 1'b1;
      gnt_id  <= 1'b0;
    end else if (CE_R) begin
      state <= state_nxt;
      rd_ph <= is_rd ? ~rd_ph : 1'b0;
      if (state == S_IDLE)
        gnt_id <= gnt_sel;
      if (state == S_DONE)
        last_id <= gnt_id;
      // DRAIN runs off the reset load; WAIT reloads on entry.
      if ((state != S_WAIT) && (state_nxt == S_WAIT))
        cnt <= CNT_W'(DIV_LAT);
      else if ((state == S_DRAIN) || (state == S_WAIT))
        cnt <= cnt - 1'b1;
    end
  end

  // Next state and bus drive
  always_comb begin
    state_nxt = state;
    DIV_REQ   = 1'b0;
    DIV_WE    = 1'b0;
    DIV_A     = 32'h0;
    DIV_DO    = 32'h0;
    case (state)
      S_DRAIN: begin
        if (cnt == CNT_W'(1))
          state_nxt = S_IDLE;
      end
      S_IDLE: begin
        if (R0_REQ || R1_REQ)
          state_nxt = S_GRANT;
      end
      S_GRANT: begin
        state_nxt = S_WR_DVSR;
      end
      S_WR_DVSR: begin
        DIV_REQ   = 1'b1;
        DIV_WE    = 1'b1;
        DIV_A     = A_DVSR;
        DIV_DO    = job_dvsr;
        state_nxt = job_div64 ? S_WR_DVDH : S_WR_START;
      end
      S_WR_DVDH: begin
        DIV_REQ   = 1'b1;
        DIV_WE    = 1'b1;
        DIV_A     = A_DVDNTH;
        DIV_DO    = job_dvdh;
        state_nxt = S_WR_START;
      end
      S_WR_START: begin
        // The low-word write is what kicks off the divide; its address
        // selects 32/32 vs 64/32 operation.
        DIV_REQ   = 1'b1;
        DIV_WE    = 1'b1;
        DIV_A     = job_div64 ? A_DVDNTL : A_DVDNT;
        DIV_DO    = job_dvdl;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == CNT_W'(1))
          state_nxt = S_RD_L;
      end
      S_RD_L: begin
        if (!rd_ph) begin
          DIV_REQ = 1'b1;
          DIV_A   = A_DVDNTL;
        end else begin
          state_nxt = S_RD_H;
        end
      end
      S_RD_H: begin
        if (!rd_ph) begin
          DIV_REQ = 1'b1;
          DIV_A   = A_DVDNTH;
        end else begin
`ifdef DIVU_ARB_OVF_CLR_EN
          state_nxt = S_RD_CR;
`else
          state_nxt = S_DONE;
`endif
        end
      end
`ifdef DIVU_ARB_OVF_CLR_EN
      S_RD_CR: begin
        if (!rd_ph) begin
          DIV_REQ = 1'b1;
          DIV_A   = A_DVCR;
        end else begin
          state_nxt = S_WR_CR;
        end
      end
      S_WR_CR: begin
        // Write back OVFIE unchanged with OVF cleared.
        DIV_REQ   = 1'b1;
        DIV_WE    = 1'b1;
        DIV_A     = A_DVCR;
        DIV_DO    = {30'b0, ovfie, 1'b0};
        state_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_DRAIN;
      end
    endcase
  end

  // Job operands and read captures (data path, no reset)
  always_ff @(posedge CLK) begin
    if (CE_R) begin
      if (state == S_GRANT) begin
        job_div64 <= gnt_id ? R1_DIV64 : R0_DIV64;
        job_dvsr  <= gnt_id ? R1_DVSR  : R0_DVSR;
        job_dvdh  <= gnt_id ? R1_DVDH  : R0_DVDH;
        job_dvdl  <= gnt_id ? R1_DVDL  : R0_DVDL;
      end
      if ((state == S_RD_L) && rd_ph)
        q_cap <= DIV_DI;
`ifdef DIVU_ARB_OVF_CLR_EN
      if ((state == S_RD_H) && rd_ph)
        r_cap <= DIV_DI;
      if ((state == S_RD_CR) && rd_ph) begin
        ovf_cap <= DIV_DI[0];
        ovfie   <= DIV_DI[1];
      end
`endif
    end
  end

  // Result outputs: updated only on the edge entering DONE, held otherwise
  always_ff @(posedge CLK) begin
    if (RST) begin
      RES_ID  <= 1'b0;
      RES_Q   <= 32'h0;
      RES_R   <= 32'h0;
`ifdef DIVU_ARB_OVF_CLR_EN
      RES_OVF <= 1'b0;
`endif
    end else if (CE_R && (state != S_DONE) && (state_nxt == S_DONE)) begin
      RES_ID  <= gnt_id;
      RES_Q   <= q_cap;
`ifdef DIVU_ARB_OVF_CLR_EN
      RES_R   <= r_cap;
      RES_OVF <= ovf_cap;
`else
      // Without the DVCR steps this edge is the remainder capture edge.
      RES_R   <= DIV_DI;
`endif
    end
  end

`ifndef DIVU_ARB_OVF_CLR_EN
  assign RES_OVF = 1'b0;
`endif

endmodule

// File: tb/tb_divu_job_arbiter.sv
// Testbench for divu_job_arbiter: a behavioural DIVU register model answers
// the arbiter's bus cycles; table-driven jobs plus hand-written sequences for
// reset drain, round-robin ordering, dropped requests and CE_R gating.
module tb_divu_job_arbiter;

  localparam int DIV_LAT = 40;

  localparam logic [31:0] A_DVSR   = 32'hFFFF_FF00;
  localparam logic [31:0] A_DVDNT  = 32'hFFFF_FF04;
  localparam logic [31:0] A_DVCR   = 32'hFFFF_FF08;
  localparam logic [31:0] A_DVDNTH = 32'hFFFF_FF10;
  localparam logic [31:0] A_DVDNTL = 32'hFFFF_FF14;

`ifdef DIVU_ARB_OVF_CLR_EN
  localparam int  EXTRA   = 3;
  localparam int  CR_WR   = 1;
  localparam bit  OVF_EXP = 1'b1;
`else
  localparam int  EXTRA   = 0;
  localparam int  CR_WR   = 0;
  localparam bit  OVF_EXP = 1'b0;
`endif
  localparam int LAT32 = 47 + EXTRA;
  localparam int LAT64 = 48 + EXTRA;

  logic        CLK = 1'b0;
  logic        RST, CE_R;
  logic        R0_REQ, R0_DIV64, R0_ACK;
  logic [31:0] R0_DVSR, R0_DVDH, R0_DVDL;
  logic        R1_REQ, R1_DIV64, R1_ACK;
  logic [31:0] R1_DVSR, R1_DVDH, R1_DVDL;
  logic        RES_DONE, RES_ID, RES_OVF;
  logic [31:0] RES_Q, RES_R;
  logic [31:0] DIV_A, DIV_DO, DIV_DI;
  logic [3:0]  DIV_BA;
  logic        DIV_WE, DIV_REQ;

  always #5 CLK = ~CLK;

  divu_job_arbiter #(.DIV_LAT(DIV_LAT)) dut (
    .CLK(CLK), .RST(RST), .CE_R(CE_R),
    .R0_REQ(R0_REQ), .R0_DIV64(R0_DIV64), .R0_DVSR(R0_DVSR), .R0_DVDH(R0_DVDH),
    .R0_DVDL(R0_DVDL), .R0_ACK(R0_ACK),
    .R1_REQ(R1_REQ), .R1_DIV64(R1_DIV64), .R1_DVSR(R1_DVSR), .R1_DVDH(R1_DVDH),
    .R1_DVDL(R1_DVDL), .R1_ACK(R1_ACK),
    .RES_DONE(RES_DONE), .RES_ID(RES_ID), .RES_Q(RES_Q), .RES_R(RES_R),
    .RES_OVF(RES_OVF),
    .DIV_A(DIV_A), .DIV_DO(DIV_DO), .DIV_BA(DIV_BA), .DIV_WE(DIV_WE),
    .DIV_REQ(DIV_REQ), .DIV_DI(DIV_DI)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // ---------------- DIVU register model ----------------
  // Signed divide; zero divisor sets OVF and returns a saturated quotient.
  function automatic logic [64:0] divu(input logic [63:0] n, input logic [31:0] d);
    logic signed [63:0] sn, sd, sq, sr;
    if (d == 32'h0) return {1'b1, 32'h7FFF_FFFF, 32'h0};
    sn = $signed(n);
    sd = $signed({{32{d[31]}}, d});
    sq = sn / sd;
    sr = sn % sd;
    return {1'b0, sq[31:0], sr[31:0]};
  endfunction

  logic [31:0] m_dvsr, m_dvdh, m_dvdl, m_dvcr;
  logic [64:0] m_res;
  logic [31:0] wr_a [0:63];
  logic [31:0] wr_d [0:63];
  int          wr_t [0:63];
  int          wr_n     = 0;
  int          ce_clk   = 0;
  int          dvcr_acc = 0;
  int          bus_viol = 0;

  assign m_res = divu((DIV_A == A_DVDNT) ? {{32{DIV_DO[31]}}, DIV_DO} : {m_dvdh, DIV_DO},
                      m_dvsr);

  always @(posedge CLK) begin
    if (RST) begin
      m_dvcr <= 32'h2;
    end else if (CE_R) begin
      ce_clk <= ce_clk + 1;
      if (DIV_REQ && DIV_A == A_DVCR) dvcr_acc <= dvcr_acc + 1;
      if (DIV_REQ && DIV_WE) begin
        if (wr_n < 64) begin
          wr_a[wr_n] <= DIV_A;
          wr_d[wr_n] <= DIV_DO;
          wr_t[wr_n] <= ce_clk;
        end
        wr_n <= wr_n + 1;
        case (DIV_A)
          A_DVSR:   m_dvsr <= DIV_DO;
          A_DVDNTH: m_dvdh <= DIV_DO;
          A_DVCR:   m_dvcr <= DIV_DO;
          A_DVDNT, A_DVDNTL: begin
            m_dvdl <= m_res[63:32];
            m_dvdh <= m_res[31:0];
            m_dvcr <= m_dvcr | {31'b0, m_res[64]};
          end
          default: ;
        endcase
      end else if (DIV_REQ) begin
        case (DIV_A)
          A_DVSR:            DIV_DI <= m_dvsr;
          A_DVDNTH:          DIV_DI <= m_dvdh;
          A_DVDNT, A_DVDNTL: DIV_DI <= m_dvdl;
          A_DVCR:            DIV_DI <= m_dvcr;
          default:           DIV_DI <= 32'h0;
        endcase
      end
    end
  end

  // Bus-idle and grant-exclusivity monitor
  always @(negedge CLK) begin
    if ((!DIV_REQ && (DIV_A != 32'h0 || DIV_DO != 32'h0 || DIV_BA != 4'h0)) ||
        (DIV_REQ && DIV_BA != 4'hF) || (R0_ACK && R1_ACK))
      bus_viol <= bus_viol + 1;
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    bit          id;
    bit          d64;
    logic [31:0] dvsr, dvdh, dvdl;
    logic [31:0] q, r;
    bit          ovf;
  } vec_t;

  task automatic drive(input vec_t v);
    if (v.id) begin
      R1_DIV64 = v.d64; R1_DVSR = v.dvsr; R1_DVDH = v.dvdh; R1_DVDL = v.dvdl; R1_REQ = 1'b1;
    end else begin
      R0_DIV64 = v.d64; R0_DVSR = v.dvsr; R0_DVDH = v.dvdh; R0_DVDL = v.dvdl; R0_REQ = 1'b1;
    end
  endtask

  // Runs one job; lat is ACK-to-DONE in CE_R cycles, -1 on timeout.
  task automatic run_job(input vec_t v, input bit ce_tog, output int lat);
    int cyc, t_ack;
    bit acked;
    cyc = 0; t_ack = 0; acked = 0; lat = -1;
    drive(v);
    for (int i = 0; i < 400; i++) begin
      CE_R = ce_tog ? ~i[0] : 1'b1;
      @(negedge CLK);
      if (CE_R) cyc++;
      if (!acked) begin
        if (v.id ? R1_ACK : R0_ACK) begin
          acked = 1'b1;
          t_ack = cyc;
          if (v.id) R1_REQ = 1'b0; else R0_REQ = 1'b0;
        end
      end else if (RES_DONE) begin
        lat = cyc - t_ack;
        break;
      end
    end
    CE_R = 1'b1;
    R0_REQ = 1'b0;
    R1_REQ = 1'b0;
  endtask

  // which: 0 R0_ACK, 1 R1_ACK, 2 RES_DONE, 3 any ACK. k = cycles, -1 on timeout.
  task automatic wait_sig(input int which, input int limit, output int k);
    k = -1;
    for (int i = 1; i <= limit; i++) begin
      @(negedge CLK);
      if ((which == 0 && R0_ACK) || (which == 1 && R1_ACK) || (which == 2 && RES_DONE) ||
          (which == 3 && (R0_ACK || R1_ACK))) begin
        k = i;
        break;
      end
    end
  endtask

  vec_t vt [6];
  vec_t vs;

  initial begin
    int lat, base, nops, k, spur;
    bit seen_done;
    logic [31:0] q_done;

    vt[0] = '{1'b0, 1'b0, 32'd7,          32'h0,        32'd100,      32'h0000_000E, 32'h2,         1'b0};
    vt[1] = '{1'b1, 1'b0, 32'd7,          32'h0,        32'hFFFF_FF9C, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0};
    vt[2] = '{1'b0, 1'b1, 32'd2,          32'h1,        32'h0,        32'h8000_0000, 32'h0,         1'b0};
    vt[3] = '{1'b0, 1'b0, 32'd0,          32'h0,        32'd5,        32'h7FFF_FFFF, 32'h0,         OVF_EXP};
    vt[4] = '{1'b1, 1'b1, 32'd16,         32'hFFFF_FFFF, 32'hFFFF_FF00, 32'hFFFF_FFF0, 32'h0,        1'b0};
    vt[5] = '{1'b1, 1'b0, 32'hFFFF_FFFD,  32'h0,        32'd10,       32'hFFFF_FFFD, 32'h1,         1'b0};

    RST = 1'b1; CE_R = 1'b1;
    R0_REQ = 0; R0_DIV64 = 0; R0_DVSR = 0; R0_DVDH = 0; R0_DVDL = 0;
    R1_REQ = 0; R1_DIV64 = 0; R1_DVSR = 0; R1_DVDH = 0; R1_DVDL = 0;
    repeat (3) @(negedge CLK);
    chk("rst_done",  {31'b0, RES_DONE}, 32'h0);
    chk("rst_acks",  {30'b0, R1_ACK, R0_ACK}, 32'h0);
    chk("rst_divreq", {31'b0, DIV_REQ}, 32'h0);
    chk("rst_div_a", DIV_A, 32'h0);
    chk("rst_res_q", RES_Q, 32'h0);
    chk("rst_res_r", RES_R, 32'h0);
    RST = 1'b0;

    // Table-driven single jobs
    for (int i = 0; i < 6; i++) begin
      base = wr_n;
      nops = vt[i].d64 ? 3 : 2;
      run_job(vt[i], 1'b0, lat);
      chk($sformatf("v%0d_lat", i), lat, vt[i].d64 ? LAT64 : LAT32);
      chk($sformatf("v%0d_id", i), {31'b0, RES_ID}, {31'b0, vt[i].id});
      chk($sformatf("v%0d_q", i), RES_Q, vt[i].q);
      chk($sformatf("v%0d_r", i), RES_R, vt[i].r);
      chk($sformatf("v%0d_ovf", i), {31'b0, RES_OVF}, {31'b0, vt[i].ovf});
      chk($sformatf("v%0d_nwr", i), wr_n - base, nops + CR_WR);
      chk($sformatf("v%0d_wr0", i), wr_a[base], A_DVSR);
      chk($sformatf("v%0d_wr0d", i), wr_d[base], vt[i].dvsr);
      chk($sformatf("v%0d_wrst", i), wr_a[base + nops - 1], vt[i].d64 ? A_DVDNTL : A_DVDNT);
      chk($sformatf("v%0d_wrstd", i), wr_d[base + nops - 1], vt[i].dvdl);
      chk($sformatf("v%0d_wrgap", i), wr_t[base + nops - 1] - wr_t[base], nops - 1);
      if (vt[i].d64)
        chk($sformatf("v%0d_wrh", i), wr_a[base + 1], A_DVDNTH);
`ifdef DIVU_ARB_OVF_CLR_EN
      chk($sformatf("v%0d_crwr", i), wr_d[base + nops], 32'h2);
      chk($sformatf("v%0d_dvcr", i), m_dvcr, 32'h2);
`endif
    end

    // Reset in WAIT, drain, then simultaneous requests
    vs = '{1'b1, 1'b0, 32'd7, 32'h0, 32'd100, 32'h0, 32'h0, 1'b0};
    drive(vs);
    wait_sig(1, 200, k);
    chk("rw_ack_seen", {31'b0, k > 0}, 32'h1);
    R1_REQ = 1'b0;
    repeat (10) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rw_divreq", {31'b0, DIV_REQ}, 32'h0);
    chk("rw_res_q", RES_Q, 32'h0);
    chk("rw_done", {31'b0, RES_DONE}, 32'h0);
    RST = 1'b0;
    vs = '{1'b0, 1'b0, 32'd7, 32'h0, 32'd100, 32'h0, 32'h0, 1'b0};
    drive(vs);
    vs = '{1'b1, 1'b1, 32'd4, 32'h0, 32'd21, 32'h0, 32'h0, 1'b0};
    drive(vs);
    wait_sig(3, 200, k);
    chk("drain_len", k, DIV_LAT + 1);
    chk("rr_first", {30'b0, R1_ACK, R0_ACK}, 32'h1);
    R0_REQ = 1'b0;
    wait_sig(2, 100, k);
    chk("rr_r0_lat", k, LAT32);
    chk("rr_r0_id", {31'b0, RES_ID}, 32'h0);
    chk("rr_r0_q", RES_Q, 32'hE);
    wait_sig(1, 10, k);
    chk("rr_r1_gap", k, 2);
    R1_REQ = 1'b0;
    @(negedge CLK);
    vs = '{1'b0, 1'b0, 32'd3, 32'h0, 32'd9, 32'h0, 32'h0, 1'b0};
    drive(vs);
    vs = '{1'b1, 1'b0, 32'd7, 32'h0, 32'hFFFF_FF9C, 32'h0, 32'h0, 1'b0};
    drive(vs);
    wait_sig(2, 100, k);
    chk("rr_r1_id", {31'b0, RES_ID}, 32'h1);
    chk("rr_r1_q", RES_Q, 32'h5);
    chk("rr_r1_r", RES_R, 32'h1);
    wait_sig(3, 10, k);
    chk("rr_second_gap", k, 2);
    chk("rr_second", {30'b0, R1_ACK, R0_ACK}, 32'h1);
    R0_REQ = 1'b0;
    wait_sig(2, 100, k);
    chk("rr_r0b_q", RES_Q, 32'h3);
    wait_sig(1, 10, k);
    chk("rr_r1b_gap", k, 2);
    R1_REQ = 1'b0;

    // R0 request withdrawn while R1 is being served: never granted
    R0_REQ = 1'b1;
    repeat (5) @(negedge CLK);
    R0_REQ = 1'b0;
    spur = 0; seen_done = 1'b0; q_done = 32'h0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (R0_ACK) spur++;
      if (RES_DONE && !seen_done) begin
        seen_done = 1'b1;
        q_done = RES_Q;
      end
    end
    chk("drop_no_ack", spur, 0);
    chk("drop_r1_done", {31'b0, seen_done}, 32'h1);
    chk("drop_r1_q", q_done, 32'hFFFF_FFF2);

    // CE_R toggling: latency counted in enabled cycles
    vs = '{1'b0, 1'b0, 32'd7, 32'h0, 32'd100, 32'h0, 32'h0, 1'b0};
    run_job(vs, 1'b1, lat);
    chk("ce_lat", lat, LAT32);
    chk("ce_q", RES_Q, 32'hE);
    chk("ce_r", RES_R, 32'h2);
    vs = '{1'b1, 1'b1, 32'd2, 32'h1, 32'h0, 32'h0, 32'h0, 1'b0};
    run_job(vs, 1'b1, lat);
    chk("ce64_lat", lat, LAT64);
    chk("ce64_q", RES_Q, 32'h8000_0000);

    repeat (2) @(negedge CLK);
    chk("bus_idle_viol", bus_viol, 0);
`ifdef DIVU_ARB_OVF_CLR_EN
    chk("dvcr_used", {31'b0, dvcr_acc > 0}, 32'h1);
`else
    chk("dvcr_untouched", dvcr_acc, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/divu_job_arbiter.md
Name: divu_job_arbiter

Overview:
- Shares the on-chip DIVU register interface between two hardware requesters, e.g. the CPU's microcoded divide path and a DMA/coprocessor job queue.
- Round-robin arbitration per job.
- Each job is sequenced as a series of IBUS writes (operands, start), a fixed wait, and IBUS reads (quotient, remainder, overflow).
- The result is returned with a done pulse.
- Sits between the requesters and the DIVU internal-bus port, as a bus master on the same CE_R/CE_F phase scheme.

Parameters:
- DIV_LAT, 40: CE_R cycles waited after the start write before results are read. Must be ≥ 39.

Ports:
- CLK  in  1  clock.
- RST  in  1  synchronous active-high reset.
- CE_R  in  1  rising-phase enable. All state advances only when high.
- R0_REQ  in  1  requester 0 job request; held until R0_ACK.
- R0_DIV64  in  1  1 = 64/32 divide, 0 = 32/32 divide.
- R0_DVSR  in  32  divisor.
- R0_DVDH  in  32  dividend high word (64-bit only).
- R0_DVDL  in  32  dividend low word / 32-bit dividend.
- R0_ACK  out  1  one-cycle grant pulse; operands are latched on this cycle.
- R1_REQ, R1_DIV64, R1_DVSR, R1_DVDH, R1_DVDL, R1_ACK: same as requester 0.
- RES_DONE  out  1  one-cycle result-valid pulse.
- RES_ID  out  1  requester index of the completed job.
- RES_Q  out  32  quotient (saturated on overflow).
- RES_R  out  32  remainder.
- RES_OVF  out  1  overflow/zero-divide flag.
- DIV_A  out  32  DIVU bus address.
- DIV_DO  out  32  DIVU write data.
- DIV_BA  out  4  byte enables; always 4'hF when DIV_REQ=1.
- DIV_WE  out  1  write strobe.
- DIV_REQ  out  1  bus request.
- DIV_DI  in  32  DIVU read data.

Behaviour:
- **Reset:** synchronous active-high RST, sampled on CLK regardless of CE_R. All outputs go to 0, the FSM goes to DRAIN, the round-robin pointer is set to favour R0, and the wait counter is loaded with DIV_LAT.
- **CE_R gating:** when CE_R=0, all state and outputs hold.
- **DRAIN state:** counts DIV_LAT CE_R cycles with no grants, so a DIVU operation interrupted by reset completes first. Then goes to IDLE.
- **IDLE state:**
  - Only one requester asserting: that requester wins.
  - Both asserting: the requester not served last wins.
  - Next state is GRANT.
- **GRANT state:** pulse Rn_ACK, latch operands, DIV64 and ID. Requests are ignored until the next IDLE.
- **WR_DVSR:** write FFFFFF00 with DVSR.
- **64-bit job:**
  - WR_DVDH: write FFFFFF10 with DVDH.
  - WR_START: write FFFFFF14 with DVDL.
- **32-bit job:**
  - WR_START: write FFFFFF04 with DVDL.
- **Bus write timing:** each write state drives DIV_REQ=1, DIV_WE=1, DIV_BA=F for exactly one CE_R cycle.
- **WAIT state:** count DIV_LAT CE_R cycles, then go to RD_L.
- **Bus read timing:** each read state lasts 2 CE_R cycles.
  - Cycle 1: DIV_REQ=1, DIV_WE=0.
  - Cycle 2: DIV_REQ=0; DIV_DI is captured.
- **Read sequence:**
  - RD_L reads FFFFFF14 into RES_Q.
  - RD_H reads FFFFFF10 into RES_R.
  - RD_CR reads FFFFFF08. RES_OVF = DI[0]; DI[1] (OVFIE) is kept.
  - WR_CR writes FFFFFF08 with {30'b0, OVFIE, 1'b0}, clearing OVF.
- **DONE state:**
  - RES_DONE=1 for one cycle.
  - RES_ID/RES_Q/RES_R/RES_OVF hold until the next DONE.
  - The round-robin pointer is updated to the served ID.
  - Next state is IDLE.
  - A request pending in DONE is granted on the following IDLE cycle. No request is lost.
- **Latency (CE_R cycles, ACK = cycle 0, default DIV_LAT):** RES_DONE at cycle 50 for a 32-bit job, 51 for a 64-bit job. Back-to-back ACKs are 52/53 cycles apart.
- **Bus idle:** DIV_A/DIV_DO = 0 whenever DIV_REQ=0.
- **Request dropped before ACK:** the arbiter does not grant it.
- **Request held after DONE:** treated as a new job.

Optional Feature:
- Macro: DIVU_ARB_OVF_CLR_EN.
- Defined: RD_CR and WR_CR are executed as described; RES_OVF is valid.
- Undefined: RD_CR and WR_CR are skipped (RD_H goes directly to DONE), RES_OVF is tied 0, and DVCR is never accessed. Latency is 47/48 cycles.

Test Plan:
- R0 32-bit, DVSR=7, DVDL=100 → ACK at 0, RES_DONE at 50; RES_ID=0, Q=0000000E, R=00000002, OVF=0. Bus writes FFFFFF00/FFFFFF04 on consecutive cycles.
- R1 32-bit, DVSR=7, DVDL=FFFFFF9C (−100) → Q=FFFFFFF2, R=FFFFFFFE.
- R0 64-bit, DVDH=1, DVDL=0, DVSR=2 → Q=80000000, R=0, OVF=0. Write sequence FFFFFF00, FFFFFF10, FFFFFF14. DONE at 51.
- R0 32-bit, DVSR=0 → OVF=1. The WR_CR write data has bit0=0, and a following DVCR read returns OVF=0.
- R0 and R1 requesting simultaneously in IDLE after reset → R0 granted first, R1 granted in the IDLE cycle after R0's DONE. Then both assert again → R0 granted (R1 served last).
- RST pulsed during WAIT → DIV_REQ=0 next cycle. No ACK for DIV_LAT cycles despite R0_REQ=1, then a normal grant and correct result.
